// File: rtl/sample_frame_buffer.sv
// -----------------------------------------------------------------------------
// sample_frame_buffer
//   Captures paired 12-bit ADC samples (channel 1 / channel 2), decimates them
//   (keeps 1 of every decimate+1 strobes), and queues the kept pairs in a
//   first-word-fall-through FIFO. The FIFO feeds the serial communicator one
//   24-bit word at a time over a valid/ready handshake. If a kept pair arrives
//   while the FIFO is full and nothing is being popped, the pair is dropped and
//   the sticky overflow flag is set.
//
// Optional build macro: SAMPLE_FRAME_BUFFER_TEST_PATTERN_EN
//   When defined, adds input test_mode. With test_mode=1 each kept pair is
//   replaced by an internal 12-bit ramp (ch1=ramp, ch2=~ramp).
//
// Ports:
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   toggled_on     in   capture enable; low flushes the block
//   ch1_sample     in   [11:0] channel 1 ADC sample
//   ch2_sample     in   [11:0] channel 2 ADC sample
//   sample_valid   in   single-cycle strobe, both samples valid
//   decimate       in   [DEC_W-1:0] keep 1 of every decimate+1 strobes
//   clear_overflow in   clears the overflow flag
//   test_mode      in   (macro only) substitute ramp for ADC samples
//   data           out  [23:0] head word, [23:12]=ch2, [11:0]=ch1
//   data_valid     out  head word available
//   data_ready     in   consumer accepts head word
//   level          out  [$clog2(DEPTH):0] entries stored
//   overflow       out  sticky: a kept sample was dropped
// -----------------------------------------------------------------------------
module sample_frame_buffer #(
  parameter int DEPTH = 16,
  parameter int DEC_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     toggled_on,
  input  logic [11:0]              ch1_sample,
  input  logic [11:0]              ch2_sample,
  input  logic                     sample_valid,
  input  logic [DEC_W-1:0]         decimate,
  input  logic                     clear_overflow,
`ifdef SAMPLE_FRAME_BUFFER_TEST_PATTERN_EN
  input  logic                     test_mode,
`endif
  output logic [23:0]              data,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [23:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [DEC_W-1:0] r_dec_cnt;
  logic             r_overflow;
  logic             r_on_d;

  logic             w_strobe;
  logic             w_keep;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_on_fall;
  logic [23:0]      w_word;

  assign w_strobe  = sample_valid && toggled_on;
  assign w_keep    = w_strobe && (r_dec_cnt == '0);
  assign w_empty   = (r_wptr == r_rptr);
  // Pointers carry one extra wrap bit: equal low bits with differing MSBs
  // means the write pointer is a full lap ahead.
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = !w_empty && data_ready && toggled_on;
  // When full, a push is only accepted if the head slot is freed this cycle.
  assign w_push    = w_keep && (!w_full || w_pop);
  assign w_drop    = w_keep && w_full && !w_pop;
  assign w_on_fall = r_on_d && !toggled_on;

`ifdef SAMPLE_FRAME_BUFFER_TEST_PATTERN_EN
  logic [11:0] r_ramp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ramp <= '0;
    end else if (!toggled_on) begin
      r_ramp <= '0;
    end else if (w_keep && test_mode) begin
      r_ramp <= r_ramp + 12'd1;
    end
  end

  assign w_word = test_mode ? {~r_ramp, r_ramp} : {ch2_sample, ch1_sample};
`else
  assign w_word = {ch2_sample, ch1_sample};
`endif

  // Decimation counter: the >= compare lets a smaller new ratio take effect
  // on the very next strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dec_cnt <= '0;
    end else if (!toggled_on) begin
      r_dec_cnt <= '0;
    end else if (w_strobe) begin
      r_dec_cnt <= (r_dec_cnt >= decimate) ? '0 : r_dec_cnt + DEC_W'(1);
    end
  end

  // Storage needs no reset: the read side masks it until a word is written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (!toggled_on) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  // A drop in the same cycle as a clear request leaves the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_on_d     <= 1'b0;
    end else begin
      r_on_d <= toggled_on;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow || w_on_fall) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign data_valid = !w_empty;
  assign data       = w_empty ? 24'd0 : r_mem[r_rptr[AW-1:0]];
  assign level      = r_wptr - r_rptr;
  assign overflow   = r_overflow;

endmodule
